// File: rtl/fifo_pkg.sv
// Shared helpers for the width-converting FIFO controller.
//   step_size(log2)  : slots moved per accepted transfer (1 << log2).
//   count_width(aw)  : bits needed to hold an occupancy of 0..2^aw.
//   count_def_t      : occupancy type for the default 16-slot build.
package fifo_pkg;

    localparam int DEF_ADDR_WIDTH = 4;

    function automatic int step_size(input int log2);
        return 1 << log2;
    endfunction

    function automatic int count_width(input int aw);
        return aw + 1;
    endfunction

    typedef logic [count_width(DEF_ADDR_WIDTH)-1:0] count_def_t;

endpackage

// File: rtl/fifo_ctrl_wc.sv
// Width-converting FIFO controller. Manages a 2^ADDR_WIDTH-slot register
// file as a circular queue: each accepted write consumes 2^WR_STEP_LOG2
// slots, each accepted read frees 2^RD_STEP_LOG2 slots.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   rd / wr      read / write requests
//   clr_err      synchronous clear of overflow/underflow
//   empty/full   a read / a write is not possible
//   almost_*     programmable occupancy thresholds
//   count        occupied slots, 0..DEPTH
//   w_addr/r_addr base slot of the current write / read
//   wr_ack/rd_ack combinational acceptance of this cycle's requests
//   overflow/underflow sticky rejected-request flags
module fifo_ctrl_wc
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH   = 4,
    parameter int WR_STEP_LOG2 = 1,
    parameter int RD_STEP_LOG2 = 0,
    parameter int AF_LEVEL     = 12,
    parameter int AE_LEVEL     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd,
    input  logic                  wr,
    input  logic                  clr_err,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  wr_ack,
    output logic                  rd_ack,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = count_width(ADDR_WIDTH);
    // One extra bit so count +/- steps never wraps before truncation.
    localparam int XW    = CW + 1;

    localparam logic [XW-1:0] WR_STEP = XW'(step_size(WR_STEP_LOG2));
    localparam logic [XW-1:0] RD_STEP = XW'(step_size(RD_STEP_LOG2));
    localparam logic [XW-1:0] DEPTH_X = XW'(DEPTH);
    localparam logic [XW-1:0] AF_X    = XW'(AF_LEVEL);
    localparam logic [XW-1:0] AE_X    = XW'(AE_LEVEL);

    localparam logic [ADDR_WIDTH-1:0] WR_PTR_STEP = ADDR_WIDTH'(step_size(WR_STEP_LOG2));
    localparam logic [ADDR_WIDTH-1:0] RD_PTR_STEP = ADDR_WIDTH'(step_size(RD_STEP_LOG2));

    if (WR_STEP_LOG2 >= ADDR_WIDTH || RD_STEP_LOG2 >= ADDR_WIDTH) begin : g_bad_step
        $fatal(1, "fifo_ctrl_wc: step must be smaller than the slot array");
    end
    if (AF_LEVEL > DEPTH || AE_LEVEL > DEPTH) begin : g_bad_level
        $fatal(1, "fifo_ctrl_wc: threshold level exceeds depth");
    end

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [XW-1:0]         w_count_x;
    logic [XW-1:0]         w_free;
    logic [XW-1:0]         w_count_sum;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_wr_ack;
    logic                  w_rd_ack;
    logic [ADDR_WIDTH-1:0] w_wr_ptr_next;
    logic [ADDR_WIDTH-1:0] w_rd_ptr_next;
    logic [CW-1:0]         w_count_next;
    logic                  w_overflow_next;
    logic                  w_underflow_next;

    always_comb begin
        w_count_x        = {1'b0, r_count};
        w_free           = DEPTH_X - w_count_x;
        w_empty          = w_count_x < RD_STEP;
        w_full           = w_free < WR_STEP;
        // Acceptance sees only pre-edge state: a same-cycle read never
        // makes room for the write.
        w_wr_ack         = wr & ~w_full;
        w_rd_ack         = rd & ~w_empty;
        w_wr_ptr_next    = r_wr_ptr;
        w_rd_ptr_next    = r_rd_ptr;
        w_count_sum      = w_count_x;
        if (w_wr_ack) begin
            w_wr_ptr_next = r_wr_ptr + WR_PTR_STEP;
            w_count_sum   = w_count_sum + WR_STEP;
        end
        if (w_rd_ack) begin
            w_rd_ptr_next = r_rd_ptr + RD_PTR_STEP;
            w_count_sum   = w_count_sum - RD_STEP;
        end
        w_count_next     = w_count_sum[CW-1:0];
        // A set in the same cycle wins over clr_err.
        w_overflow_next  = (wr & w_full) | (r_overflow & ~clr_err);
        w_underflow_next = (rd & w_empty) | (r_underflow & ~clr_err);

        empty        = w_empty;
        full         = w_full;
        almost_empty = w_count_x <= AE_X;
        almost_full  = w_count_x >= AF_X;
        count        = r_count;
        w_addr       = r_wr_ptr;
        r_addr       = r_rd_ptr;
        wr_ack       = w_wr_ack;
        rd_ack       = w_rd_ack;
        overflow     = r_overflow;
        underflow    = r_underflow;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_next;
            r_rd_ptr    <= w_rd_ptr_next;
            r_count     <= w_count_next;
            r_overflow  <= w_overflow_next;
            r_underflow <= w_underflow_next;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl_wc.sv
module tb_fifo_ctrl_wc;

    logic clk;
    logic reset;
    logic rd;
    logic wr;
    logic clr_err;
    logic sel;

    // Default build (write step 2, read step 1)
    logic       d0_empty, d0_full, d0_ae, d0_af, d0_wack, d0_rack, d0_ov, d0_un;
    logic [4:0] d0_count;
    logic [3:0] d0_waddr, d0_raddr;
    // Mirror build (write step 1, read step 4)
    logic       d1_empty, d1_full, d1_ae, d1_af, d1_wack, d1_rack, d1_ov, d1_un;
    logic [4:0] d1_count;
    logic [3:0] d1_waddr, d1_raddr;

    fifo_ctrl_wc u_dut (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .clr_err(clr_err),
        .empty(d0_empty), .full(d0_full), .almost_empty(d0_ae), .almost_full(d0_af),
        .count(d0_count), .w_addr(d0_waddr), .r_addr(d0_raddr),
        .wr_ack(d0_wack), .rd_ack(d0_rack), .overflow(d0_ov), .underflow(d0_un)
    );

    fifo_ctrl_wc #(
        .ADDR_WIDTH(4), .WR_STEP_LOG2(0), .RD_STEP_LOG2(2), .AF_LEVEL(12), .AE_LEVEL(2)
    ) u_dut_mirror (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .clr_err(clr_err),
        .empty(d1_empty), .full(d1_full), .almost_empty(d1_ae), .almost_full(d1_af),
        .count(d1_count), .w_addr(d1_waddr), .r_addr(d1_raddr),
        .wr_ack(d1_wack), .rd_ack(d1_rack), .overflow(d1_ov), .underflow(d1_un)
    );

    logic       o_empty, o_full, o_ae, o_af, o_wack, o_rack, o_ov, o_un;
    logic [4:0] o_count;
    logic [3:0] o_waddr, o_raddr;

    always_comb begin
        o_empty = sel ? d1_empty : d0_empty;
        o_full  = sel ? d1_full  : d0_full;
        o_ae    = sel ? d1_ae    : d0_ae;
        o_af    = sel ? d1_af    : d0_af;
        o_wack  = sel ? d1_wack  : d0_wack;
        o_rack  = sel ? d1_rack  : d0_rack;
        o_ov    = sel ? d1_ov    : d0_ov;
        o_un    = sel ? d1_un    : d0_un;
        o_count = sel ? d1_count : d0_count;
        o_waddr = sel ? d1_waddr : d0_waddr;
        o_raddr = sel ? d1_raddr : d0_raddr;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the selected build
    int   m_ws, m_rs, m_depth, m_af, m_ae;
    int   m_wp, m_rp, m_cnt;
    logic m_ov, m_un;

    typedef struct {
        logic wack;
        logic rack;
        int   waddr_pre;
        int   raddr_pre;
        int   cnt;
        int   wp;
        int   rp;
        logic empty;
        logic full;
        logic ae;
        logic af;
        logic ov;
        logic un;
    } exp_t;

    exp_t exp_q[$];

    // Values observed at the falling edge before the update
    logic       obs_wack, obs_rack;
    logic [3:0] obs_waddr, obs_raddr;

    task automatic model_reset();
        m_wp = 0; m_rp = 0; m_cnt = 0; m_ov = 1'b0; m_un = 1'b0;
    endtask

    task automatic set_cfg(input logic s);
        sel = s;
        m_depth = 16; m_af = 12; m_ae = 2;
        if (s) begin m_ws = 1; m_rs = 4; end
        else   begin m_ws = 2; m_rs = 1; end
    endtask

    // Drives one request cycle (entered/exited at posedge+1) and pushes the
    // model's expectation for it onto the scoreboard.
    task automatic step(input logic r, input logic w, input logic c);
        exp_t e;
        logic mf, me;
        rd = r; wr = w; clr_err = c;
        @(negedge clk);
        obs_wack = o_wack; obs_rack = o_rack;
        obs_waddr = o_waddr; obs_raddr = o_raddr;
        mf = (m_depth - m_cnt) < m_ws;
        me = m_cnt < m_rs;
        e.wack = w && !mf;
        e.rack = r && !me;
        e.waddr_pre = m_wp;
        e.raddr_pre = m_rp;
        if (e.wack) begin m_wp = (m_wp + m_ws) % m_depth; m_cnt += m_ws; end
        if (e.rack) begin m_rp = (m_rp + m_rs) % m_depth; m_cnt -= m_rs; end
        m_ov = (w && mf) || (m_ov && !c);
        m_un = (r && me) || (m_un && !c);
        e.cnt = m_cnt; e.wp = m_wp; e.rp = m_rp;
        e.empty = m_cnt < m_rs;
        e.full  = (m_depth - m_cnt) < m_ws;
        e.ae    = m_cnt <= m_ae;
        e.af    = m_cnt >= m_af;
        e.ov = m_ov; e.un = m_un;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0; clr_err = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        set_cfg(1'b0);
        do_reset();
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        exp_q.delete();
        // Mid-cycle reset, no clock edge in between
        #2 reset = 1'b0;
        model_reset();
        #1;
        n_checks++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", o_empty); end
        n_checks++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", o_full); end
        n_checks++; if (o_count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", o_count); end
        n_checks++; if (o_waddr !== 4'd0) begin n_fail++; $display("FAIL reset_waddr got %0d want 0", o_waddr); end
        n_checks++; if (o_raddr !== 4'd0) begin n_fail++; $display("FAIL reset_raddr got %0d want 0", o_raddr); end
        n_checks++; if (o_ov !== 1'b0 || o_un !== 1'b0) begin n_fail++; $display("FAIL reset_err got ov=%b un=%b want 0 0", o_ov, o_un); end
        n_checks++; if (o_ae !== 1'b1 || o_af !== 1'b0) begin n_fail++; $display("FAIL reset_almost got ae=%b af=%b want 1 0", o_ae, o_af); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_fill_overflow();
        exp_t e;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0);
            e = exp_q.pop_front();
            n_checks++; if (obs_wack !== e.wack) begin n_fail++; $display("FAIL fill_wack[%0d] got %b want %b", i, obs_wack, e.wack); end
            n_checks++; if (int'(obs_waddr) !== 2 * i) begin n_fail++; $display("FAIL fill_waddr[%0d] got %0d want %0d", i, obs_waddr, 2 * i); end
            n_checks++; if (int'(o_count) !== e.cnt) begin n_fail++; $display("FAIL fill_count[%0d] got %0d want %0d", i, o_count, e.cnt); end
            $display("fill write %0d: w_addr=%0d count=%0d", i, obs_waddr, o_count);
        end
        n_checks++; if (o_waddr !== 4'd0) begin n_fail++; $display("FAIL fill_wrap got %0d want 0", o_waddr); end
        n_checks++; if (o_full !== 1'b1 || o_af !== 1'b1 || o_count !== 5'd16) begin n_fail++; $display("FAIL fill_full got full=%b af=%b cnt=%0d want 1 1 16", o_full, o_af, o_count); end
        step(1'b0, 1'b1, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if (obs_wack !== 1'b0 || e.wack !== 1'b0) begin n_fail++; $display("FAIL ovf_wack got %b want 0", obs_wack); end
        n_checks++; if (o_ov !== 1'b1 || o_count !== 5'd16 || o_waddr !== 4'd0) begin n_fail++; $display("FAIL ovf_state got ov=%b cnt=%0d wa=%0d want 1 16 0", o_ov, o_count, o_waddr); end
        $display("test_fill_overflow done");
    endtask

    task automatic test_odd_free();
        exp_t e;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 1'b0);
            e = exp_q.pop_front();
        end
        step(1'b1, 1'b0, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if (o_count !== 5'd13) begin n_fail++; $display("FAIL odd_count13 got %0d want 13", o_count); end
        step(1'b0, 1'b1, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if (o_count !== 5'd15 || o_full !== 1'b1) begin n_fail++; $display("FAIL odd_full15 got cnt=%0d full=%b want 15 1", o_count, o_full); end
        step(1'b0, 1'b1, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if (obs_wack !== e.wack || o_count !== 5'd15 || o_ov !== 1'b1) begin n_fail++; $display("FAIL odd_reject got ack=%b cnt=%0d ov=%b want 0 15 1", obs_wack, o_count, o_ov); end
        step(1'b1, 1'b0, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if (o_count !== 5'd14 || o_full !== 1'b0) begin n_fail++; $display("FAIL odd_read14 got cnt=%0d full=%b want 14 0", o_count, o_full); end
        $display("test_odd_free done: count=%0d", o_count);
    endtask

    // Continues from count=14 left by test_odd_free
    task automatic test_simultaneous();
        exp_t e;
        logic [3:0] wa0, ra0;
        wa0 = o_waddr; ra0 = o_raddr;
        step(1'b1, 1'b1, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if (obs_wack !== 1'b1 || obs_rack !== 1'b1) begin n_fail++; $display("FAIL sim_both_ack got w=%b r=%b want 1 1", obs_wack, obs_rack); end
        n_checks++; if (o_count !== 5'd15 || o_waddr !== wa0 + 4'd2 || o_raddr !== ra0 + 4'd1) begin n_fail++; $display("FAIL sim_both_state got cnt=%0d wa=%0d ra=%0d want 15 %0d %0d", o_count, o_waddr, o_raddr, wa0 + 4'd2, ra0 + 4'd1); end
        step(1'b1, 1'b0, 1'b0);
        e = exp_q.pop_front();
        step(1'b0, 1'b1, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if (o_count !== 5'd16) begin n_fail++; $display("FAIL sim_refill got %0d want 16", o_count); end
        step(1'b1, 1'b1, 1'b1);
        e = exp_q.pop_front();
        n_checks++; if (obs_wack !== 1'b0 || obs_rack !== 1'b1) begin n_fail++; $display("FAIL sim_full_ack got w=%b r=%b want 0 1", obs_wack, obs_rack); end
        n_checks++; if (o_count !== 5'd15 || o_ov !== 1'b1) begin n_fail++; $display("FAIL sim_full_state got cnt=%0d ov=%b want 15 1", o_count, o_ov); end
        $display("test_simultaneous done");
    endtask

    task automatic test_underflow_clear();
        exp_t e;
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if (obs_rack !== 1'b0 || o_un !== 1'b1) begin n_fail++; $display("FAIL unf_set got ack=%b un=%b want 0 1", obs_rack, o_un); end
        step(1'b1, 1'b0, 1'b1);
        e = exp_q.pop_front();
        n_checks++; if (o_un !== e.un || o_un !== 1'b1) begin n_fail++; $display("FAIL unf_set_wins got %b want 1", o_un); end
        step(1'b0, 1'b0, 1'b1);
        e = exp_q.pop_front();
        n_checks++; if (o_un !== 1'b0) begin n_fail++; $display("FAIL unf_clear got %b want 0", o_un); end
        $display("test_underflow_clear done");
    endtask

    task automatic test_random();
        exp_t e;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) == 0));
            e = exp_q.pop_front();
            n_checks++;
            if (obs_wack !== e.wack || obs_rack !== e.rack ||
                int'(obs_waddr) !== e.waddr_pre || int'(obs_raddr) !== e.raddr_pre ||
                int'(o_count) !== e.cnt || int'(o_waddr) !== e.wp || int'(o_raddr) !== e.rp ||
                o_empty !== e.empty || o_full !== e.full || o_ae !== e.ae || o_af !== e.af ||
                o_ov !== e.ov || o_un !== e.un) begin
                n_fail++;
                $display("FAIL rand[%0d] got ack=%b%b cnt=%0d wa=%0d ra=%0d e/f=%b%b ae/af=%b%b ov/un=%b%b want ack=%b%b cnt=%0d wa=%0d ra=%0d e/f=%b%b ae/af=%b%b ov/un=%b%b",
                         i, obs_wack, obs_rack, o_count, o_waddr, o_raddr, o_empty, o_full, o_ae, o_af, o_ov, o_un,
                         e.wack, e.rack, e.cnt, e.wp, e.rp, e.empty, e.full, e.ae, e.af, e.ov, e.un);
            end
        end
        $display("test_random done");
    endtask

    task automatic test_mirror();
        exp_t e;
        set_cfg(1'b1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0);
            e = exp_q.pop_front();
        end
        n_checks++; if (o_empty !== 1'b1 || o_count !== 5'd3) begin n_fail++; $display("FAIL mir_empty3 got e=%b cnt=%0d want 1 3", o_empty, o_count); end
        step(1'b0, 1'b1, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if (o_empty !== 1'b0 || o_count !== 5'd4) begin n_fail++; $display("FAIL mir_empty4 got e=%b cnt=%0d want 0 4", o_empty, o_count); end
        step(1'b1, 1'b0, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if (obs_raddr !== 4'd0 || o_raddr !== 4'd4 || o_count !== 5'd0) begin n_fail++; $display("FAIL mir_read got ra %0d->%0d cnt=%0d want 0->4 0", obs_raddr, o_raddr, o_count); end
        step(1'b0, 1'b1, 1'b0);
        e = exp_q.pop_front();
        step(1'b1, 1'b1, 1'b0);
        e = exp_q.pop_front();
        n_checks++; if (o_un !== 1'b1 || o_count !== 5'd2) begin n_fail++; $display("FAIL mir_unf got un=%b cnt=%0d want 1 2", o_un, o_count); end
        #2 reset = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (o_count !== 5'd0 || o_waddr !== 4'd0 || o_raddr !== 4'd0 || o_empty !== 1'b1 ||
            o_full !== 1'b0 || o_ov !== 1'b0 || o_un !== 1'b0 || o_ae !== 1'b1 || o_af !== 1'b0) begin
            n_fail++;
            $display("FAIL mir_async_reset got cnt=%0d wa=%0d ra=%0d e=%b f=%b ov=%b un=%b ae=%b af=%b want 0 0 0 1 0 0 0 1 0",
                     o_count, o_waddr, o_raddr, o_empty, o_full, o_ov, o_un, o_ae, o_af);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        $display("test_mirror done");
    endtask

    initial begin
        reset = 1'b0; rd = 1'b0; wr = 1'b0; clr_err = 1'b0;
        set_cfg(1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        test_reset();
        test_fill_overflow();
        test_odd_free();
        test_simultaneous();
        test_underflow_clear();
        test_random();
        test_mirror();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d entries left want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl_wc.md
Name: fifo_ctrl_wc

Overview:
Parametrised width-converting FIFO controller. It manages a 2^ADDR_WIDTH-slot register file as a circular queue in which each write consumes 2^WR_STEP_LOG2 slots and each read frees 2^RD_STEP_LOG2 slots. It generalises the fixed 2:1 write-wide controller to any power-of-two ratio in either direction. It also adds an occupancy count, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags. It sits beside the register file in the audio/data buffering path and drives its w_addr/r_addr.

Parameters:
ADDR_WIDTH, 4, slot address width; DEPTH = 2^ADDR_WIDTH slots.
WR_STEP_LOG2, 1, log2 of slots consumed per accepted write.
RD_STEP_LOG2, 0, log2 of slots freed per accepted read.
AF_LEVEL, 12, almost_full asserted when count >= AF_LEVEL.
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset (asserted at 0).
rd  in  1  read request.
wr  in  1  write request.
clr_err  in  1  synchronous clear of the sticky error flags.
empty  out  1  count < 2^RD_STEP_LOG2; a read is not possible.
full  out  1  DEPTH - count < 2^WR_STEP_LOG2; a write is not possible.
almost_empty  out  1  count <= AE_LEVEL.
almost_full  out  1  count >= AF_LEVEL.
count  out  ADDR_WIDTH+1  occupied slots, range 0..DEPTH.
w_addr  out  ADDR_WIDTH  base slot for the current write; always a multiple of 2^WR_STEP_LOG2.
r_addr  out  ADDR_WIDTH  base slot for the current read; always a multiple of 2^RD_STEP_LOG2.
wr_ack  out  1  combinational: the write this cycle is accepted.
rd_ack  out  1  combinational: the read this cycle is accepted.
overflow  out  1  sticky: a write was rejected.
underflow  out  1  sticky: a read was rejected.

Behaviour:
- State registers: wr_ptr, rd_ptr, count, overflow, underflow. All other outputs decode from these registers plus rd/wr.
- Reset (reset=0, asynchronous, no clock needed): wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0. Consequently empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0), w_addr=r_addr=0.
- A reset asserted mid-operation discards all queue state immediately.
- Release of reset is synchronised by the integrator; this block adds no synchroniser.
- Acceptance is evaluated against pre-edge state only:
  - wr_ack = wr & ~full.
  - rd_ack = rd & ~empty.
  - rd and wr are independent; both may be accepted in the same cycle. Because a write is only accepted against the pre-edge free space, a same-cycle read never frees space for that write.
- On each rising clk edge with reset=1:
  - wr_ack: wr_ptr += 2^WR_STEP_LOG2, modulo DEPTH (natural wrap).
  - rd_ack: rd_ptr += 2^RD_STEP_LOG2, modulo DEPTH.
  - count += (wr_ack ? 2^WR_STEP_LOG2 : 0) - (rd_ack ? 2^RD_STEP_LOG2 : 0), computed at ADDR_WIDTH+2 bits, then truncated. The result never leaves 0..DEPTH.
- Error flags:
  - wr & full sets overflow; rd & empty sets underflow.
  - clr_err clears both, but a same-cycle set takes priority over the clear.
- Read-data latency is owned by the register file; the controller presents r_addr for the current head with zero cycles of lookahead.
- Elaboration checks (fatal):
  - WR_STEP_LOG2 < ADDR_WIDTH and RD_STEP_LOG2 < ADDR_WIDTH.
  - AF_LEVEL <= DEPTH and AE_LEVEL <= DEPTH.
- With WR_STEP_LOG2=RD_STEP_LOG2=0 the block behaves as a conventional FIFO controller.

Decomposition:
- Package fifo_pkg holds a function computing the step constant (1 << log2) and a typedef for the count width (ADDR_WIDTH+1) as a parametrised-width helper.
- No sub-module: pointer, count and flag logic is one always_ff plus one always_comb.

Test Plan:
All scenarios use the defaults (DEPTH 16, write step 2, read step 1) unless stated.
1. Reset: drive reset=0 with no clk edge -> empty=1, full=0, count=0, w_addr=0, r_addr=0, overflow=0 immediately.
2. Fill and overflow:
   - 8 consecutive writes -> w_addr sequence 0,2,4,...,14, then wraps to 0; count=16, full=1, almost_full=1.
   - A 9th write -> wr_ack=0, overflow=1, state unchanged.
3. Odd free space:
   - 7 writes, then 1 read -> count=13.
   - Next write -> count=15; full=1 because free=1 < 2.
   - Next write -> rejected.
   - 1 read -> count=14, full=0.
4. Simultaneous request:
   - count=14, rd=wr=1 -> both acked; count=15, r_addr+1, w_addr+2.
   - count=16, rd=wr=1 -> only the read is acked; count=15, overflow=1.
5. Underflow and clear:
   - From reset, a read -> rd_ack=0, underflow=1.
   - clr_err=1 together with a rejected read -> underflow stays 1.
   - clr_err alone -> underflow=0.
6. Mirror config (WR_STEP_LOG2=0, RD_STEP_LOG2=2):
   - 3 writes -> empty=1 (3 < 4).
   - 4th write -> empty=0.
   - Read -> r_addr 0 to 4, count=0.
   - Assert reset mid-sequence -> all outputs return to reset values asynchronously.
